// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-dump block.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
    typedef enum logic [1:0] {SEQ_IDLE, SEQ_SEND, SEQ_WAIT} seq_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int NUM_CHARS            = 26;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9)
            hex_char = ASCII_ZERO + {4'd0, n};
        else
            hex_char = ASCII_A + {4'd0, n - 4'd10};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; tx_ready is high in the cycle a new byte can be taken,
// including the last stop-bit cycle so characters chain without an idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             txd_q;
    logic             bit_end;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign tx_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign txd      = txd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    txd_q <= 1'b1;
                    if (tx_valid) begin
                        sh_q    <= tx_data;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                        sh_q    <= {1'b0, sh_q[7:1]};
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= sh_q[0];
                            sh_q  <= {1'b0, sh_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        // Next start bit follows the final stop cycle directly.
                        if (tx_valid) begin
                            sh_q    <= tx_data;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_dump.sv
// Dumps eight 8-bit registers over UART as "HH HH ... HH \r\n" (26 characters)
// on each accepted start request.
module uart_reg_dump
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] S0,
    input  logic [7:0] S1,
    input  logic [7:0] S2,
    input  logic [7:0] S3,
    input  logic [7:0] S4,
    input  logic [7:0] S5,
    input  logic [7:0] S6,
    input  logic [7:0] S7,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    seq_state_e      seq_q;
    logic [4:0]      idx_q;
    logic [7:0][7:0] buf_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0][7:0] live;
    logic [7:0][7:0] src;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;

    function automatic logic [7:0] char_at(input logic [7:0][7:0] regs, input logic [4:0] idx);
        char_at = ASCII_LF;
        if (idx == 5'd24) begin
            char_at = ASCII_CR;
        end else if (idx < 5'd24) begin
            for (int k = 0; k < 8; k++) begin
                if (idx == 5'(3 * k))     char_at = hex_char(regs[k][7:4]);
                if (idx == 5'(3 * k + 1)) char_at = hex_char(regs[k][3:0]);
                if (idx == 5'(3 * k + 2)) char_at = ASCII_SPACE;
            end
        end
    endfunction

    assign live = {S7, S6, S5, S4, S3, S2, S1, S0};
    // Character 0 leaves on the accepting edge, so it is encoded from the live inputs.
    assign src      = (seq_q == SEQ_IDLE) ? live : buf_q;
    assign tx_data  = char_at(src, idx_q);
    assign tx_valid = ((seq_q == SEQ_IDLE) && start) || (seq_q == SEQ_SEND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q  <= SEQ_IDLE;
            idx_q  <= '0;
            buf_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (seq_q)
                SEQ_IDLE: begin
                    idx_q <= '0;
                    if (tx_valid && tx_ready) begin
                        buf_q  <= live;
                        busy_q <= 1'b1;
                        idx_q  <= 5'd1;
                        seq_q  <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (tx_ready) begin
                        if (idx_q == 5'(NUM_CHARS - 1)) begin
                            idx_q <= '0;
                            seq_q <= SEQ_WAIT;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                SEQ_WAIT: begin
                    // tx_ready here marks the final stop cycle of the last character.
                    if (tx_ready) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        seq_q  <= SEQ_IDLE;
                    end
                end
                default: seq_q <= SEQ_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .txd     (txd)
    );

endmodule
